// File: rtl/rect_motion_ctl_if.sv
// rect_motion_ctl_if -- frame/mouse inputs and rectangle position outputs of
// rect_motion_ctl. The master side drives the mouse and vblnk, the slave side
// (the controller) drives xpos/ypos/busy.
interface rect_motion_ctl_if;
    logic        vblnk;
    logic        mouse_left;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        busy;

    modport master (
        output vblnk, mouse_left, mouse_xpos, mouse_ypos,
        input  xpos, ypos, busy
    );

    modport slave (
        input  vblnk, mouse_left, mouse_xpos, mouse_ypos,
        output xpos, ypos, busy
    );
endinterface

// File: rtl/rect_motion_ctl.sv
// rect_motion_ctl -- positions the drawn rectangle from pclk-domain mouse data.
// TRACK follows the mouse, ARMED waits for the left button to be released,
// FALL runs fixed-point gravity with damped floor bounces (one step per vblnk
// rising edge), REST holds on the floor until the button is pressed again.
// Optional feature: define RECT_MOTION_HVEL_EN to carry the mouse's horizontal
// velocity into the fall, reflecting off the left and right limits.
module rect_motion_ctl #(
    parameter int SCREEN_W     = 800,
    parameter int SCREEN_H     = 600,
    parameter int RECT_W       = 48,
    parameter int RECT_H       = 64,
    parameter int FRAC         = 4,
    parameter int GRAV         = 16,
    parameter int BOUNCE_SHIFT = 1,
    parameter int REST_VEL     = 16,
    parameter int MAX_BOUNCES  = 8
) (
    input  logic             pclk,
    input  logic             rst,
    rect_motion_ctl_if.slave bus
);
    localparam int XMAX = SCREEN_W - RECT_W;
    localparam int YMAX = SCREEN_H - RECT_H;
    localparam int PW   = 12 + FRAC;              // position width
    localparam int VW   = 13 + FRAC;              // signed velocity width
    localparam int SW   = VW + 2;                 // headroom for pos + vel
    localparam int BW   = $clog2(MAX_BOUNCES + 1);
    localparam logic signed [SW-1:0] FLOOR_FX = SW'(YMAX * (2 ** FRAC));

    typedef enum logic [1:0] {S_TRACK, S_ARMED, S_FALL, S_REST} state_t;

    state_t               state, state_d;
    logic [11:0]          xpos_q, xpos_d;
    logic [11:0]          ypos_q, ypos_d;
    logic [PW-1:0]        pos_fx, pos_d;
    logic signed [VW-1:0] vel, vel_d;
    logic [BW-1:0]        bounce_cnt, bcnt_d, bcnt_inc;
    logic                 vblnk_q;
    logic                 tick;

    logic signed [SW-1:0] vel_inc;
    logic signed [SW-1:0] pos_sum;
    logic signed [SW-1:0] vel_bounce;
    logic signed [SW-1:0] vel_mag;

`ifdef RECT_MOTION_HVEL_EN
    logic signed [12:0] hvel, hvel_d, hvel_sat, hvel_diff;
    logic [11:0]        mouse_xpos_prev;
    logic signed [14:0] x_sum;
`endif

    function automatic logic [11:0] clamp_x(input logic [11:0] v);
        return (int'(v) > XMAX) ? 12'(XMAX) : v;
    endfunction

    function automatic logic [11:0] clamp_y(input logic [11:0] v);
        return (int'(v) > YMAX) ? 12'(YMAX) : v;
    endfunction

    // Frame tick is the first pclk cycle of vblnk high.
    assign tick = bus.vblnk & ~vblnk_q;

    // Gravity step: the velocity is updated before it moves the position.
    assign vel_inc    = SW'(vel) + SW'(GRAV);
    assign pos_sum    = $signed({{(SW - PW){1'b0}}, pos_fx}) + vel_inc;
    assign vel_bounce = -(vel_inc >>> BOUNCE_SHIFT);
    assign vel_mag    = (vel_bounce < 0) ? -vel_bounce : vel_bounce;
    assign bcnt_inc   = bounce_cnt + BW'(1);

`ifdef RECT_MOTION_HVEL_EN
    assign hvel_diff = $signed({1'b0, bus.mouse_xpos}) - $signed({1'b0, mouse_xpos_prev});
    assign hvel_sat  = (hvel > 13'sd15) ? 13'sd15 : ((hvel < -13'sd15) ? -13'sd15 : hvel);
    assign x_sum     = $signed({3'b000, xpos_q}) + 15'(hvel);
`endif

    assign bus.xpos = xpos_q;
    assign bus.ypos = ypos_q;
    assign bus.busy = (state == S_FALL);

    // State register.
    // NOTE: registers take non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) state <= S_TRACK;
        else      state <= state_d;
    end

    // Position, velocity, bounce counter and vblnk edge detector.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            xpos_q     <= '0;
            ypos_q     <= '0;
            pos_fx     <= '0;
            vel        <= '0;
            bounce_cnt <= '0;
            vblnk_q    <= 1'b0;
        end else begin
            xpos_q     <= xpos_d;
            ypos_q     <= ypos_d;
            pos_fx     <= pos_d;
            vel        <= vel_d;
            bounce_cnt <= bcnt_d;
            vblnk_q    <= bus.vblnk;
        end
    end

`ifdef RECT_MOTION_HVEL_EN
    // Horizontal velocity and the mouse x seen at the previous frame tick.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            hvel            <= '0;
            mouse_xpos_prev <= '0;
        end else begin
            hvel <= hvel_d;
            if (tick) mouse_xpos_prev <= bus.mouse_xpos;
        end
    end
`endif

    // Next state and next datapath values.
    // NOTE: every target gets a default first, so no path through the case infers a latch.
    always_comb begin
        state_d = state;
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;
        pos_d   = pos_fx;
        vel_d   = vel;
        bcnt_d  = bounce_cnt;
`ifdef RECT_MOTION_HVEL_EN
        hvel_d  = hvel;
`endif
        unique case (state)
            S_TRACK: begin
                xpos_d = clamp_x(bus.mouse_xpos);
                ypos_d = clamp_y(bus.mouse_ypos);
`ifdef RECT_MOTION_HVEL_EN
                hvel_d = '0;
`endif
                if (bus.mouse_left) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (bus.mouse_left) begin
                    xpos_d = clamp_x(bus.mouse_xpos);
                    ypos_d = clamp_y(bus.mouse_ypos);
`ifdef RECT_MOTION_HVEL_EN
                    if (tick) hvel_d = hvel_diff;
`endif
                end else begin
                    // Release: drop from the last tracked height, ignoring any tick this cycle.
                    state_d = S_FALL;
                    pos_d   = {ypos_q, {FRAC{1'b0}}};
                    vel_d   = '0;
                    bcnt_d  = '0;
`ifdef RECT_MOTION_HVEL_EN
                    hvel_d  = hvel_sat;
`endif
                end
            end
            S_FALL: begin
                if (tick) begin
`ifdef RECT_MOTION_HVEL_EN
                    if (x_sum <= 15'sd0) begin
                        xpos_d = '0;
                        hvel_d = -hvel;
                    end else if (x_sum >= 15'(XMAX)) begin
                        xpos_d = 12'(XMAX);
                        hvel_d = -hvel;
                    end else begin
                        xpos_d = x_sum[11:0];
                    end
`endif
                    if (pos_sum >= FLOOR_FX) begin
                        pos_d  = FLOOR_FX[PW-1:0];
                        vel_d  = vel_bounce[VW-1:0];
                        bcnt_d = bcnt_inc;
                        if (vel_mag < SW'(REST_VEL) || bcnt_inc == BW'(MAX_BOUNCES)) begin
                            vel_d   = '0;
                            state_d = S_REST;
`ifdef RECT_MOTION_HVEL_EN
                            hvel_d  = '0;
`endif
                        end
                    end else if (pos_sum < 0) begin
                        pos_d = '0;
                        vel_d = '0;
                    end else begin
                        pos_d = pos_sum[PW-1:0];
                        vel_d = vel_inc[VW-1:0];
                    end
                    ypos_d = pos_d[PW-1:FRAC];
                end
            end
            S_REST: begin
                if (bus.mouse_left) state_d = S_TRACK;
            end
            default: state_d = S_TRACK;
        endcase
    end
endmodule

// File: tb/tb_rect_motion_ctl.sv
// tb_rect_motion_ctl -- randomized scoreboard bench for rect_motion_ctl.
// The driver pushes the reference model's expected outputs for every clock
// edge; a negedge monitor pops and compares them. Directed checks cover the
// reset, clamp, fall, bounce, rest and simultaneous-event cases.
module tb_rect_motion_ctl;
    localparam int XMAX     = 752;
    localparam int YMAX     = 536;
    localparam int FLOOR_FX = YMAX * 16;

    typedef enum int {M_TRACK, M_ARMED, M_FALL, M_REST} mode_t;
    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
        logic        busy;
    } exp_t;

    logic pclk = 1'b0;
    logic rst  = 1'b0;

    rect_motion_ctl_if bus ();

    rect_motion_ctl dut (
        .pclk(pclk),
        .rst (rst),
        .bus (bus)
    );

    always #5 pclk = ~pclk;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model state.
    mode_t m_mode;
    int    m_x, m_y, m_yf, m_v, m_nb, m_hv, m_mxprev;
    bit    m_vb_prev;
    bit    m_bounced;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clampx(input int v);
        return (v > XMAX) ? XMAX : v;
    endfunction

    function automatic int clampy(input int v);
        return (v > YMAX) ? YMAX : v;
    endfunction

    task automatic model_reset();
        m_mode    = M_TRACK;
        m_x       = 0;
        m_y       = 0;
        m_yf      = 0;
        m_v       = 0;
        m_nb      = 0;
        m_hv      = 0;
        m_mxprev  = 0;
        m_vb_prev = 1'b0;
    endtask

    // Outputs expected after one clock edge with the given inputs.
    task automatic model_edge(input bit vb, input bit ml, input int mx, input int my);
        bit tick;
        int xs;
        tick      = vb && !m_vb_prev;
        m_vb_prev = vb;
        case (m_mode)
            M_TRACK: begin
                m_x  = clampx(mx);
                m_y  = clampy(my);
                m_hv = 0;
                if (ml) m_mode = M_ARMED;
            end
            M_ARMED: begin
                if (ml) begin
                    m_x = clampx(mx);
                    m_y = clampy(my);
                    if (tick) m_hv = mx - m_mxprev;
                end else begin
                    m_mode = M_FALL;
                    m_yf   = m_y * 16;
                    m_v    = 0;
                    m_nb   = 0;
                    m_hv   = (m_hv > 15) ? 15 : ((m_hv < -15) ? -15 : m_hv);
                end
            end
            M_FALL: begin
                if (tick) begin
`ifdef RECT_MOTION_HVEL_EN
                    xs = m_x + m_hv;
                    if (xs <= 0) begin
                        m_x  = 0;
                        m_hv = -m_hv;
                    end else if (xs >= XMAX) begin
                        m_x  = XMAX;
                        m_hv = -m_hv;
                    end else begin
                        m_x = xs;
                    end
`else
                    xs = m_x;
`endif
                    m_v  = m_v + 16;
                    m_yf = m_yf + m_v;
                    if (m_yf >= FLOOR_FX) begin
                        m_yf      = FLOOR_FX;
                        m_v       = -(m_v / 2);
                        m_nb      = m_nb + 1;
                        m_bounced = 1'b1;
                        if (((m_v < 0) ? -m_v : m_v) < 16 || m_nb == 8) begin
                            m_v    = 0;
                            m_hv   = 0;
                            m_mode = M_REST;
                        end
                    end else if (m_yf < 0) begin
                        m_yf = 0;
                        m_v  = 0;
                    end
                    m_y = m_yf / 16;
                end
            end
            M_REST: begin
                if (ml) m_mode = M_TRACK;
            end
            default: m_mode = M_TRACK;
        endcase
        if (tick) m_mxprev = mx;
    endtask

    // Drive one cycle of inputs, queue the expected response, return #2 after the edge.
    task automatic step(input bit vb, input bit ml, input int mx, input int my);
        exp_t e;
        bus.vblnk      = vb;
        bus.mouse_left = ml;
        bus.mouse_xpos = 12'(mx);
        bus.mouse_ypos = 12'(my);
        model_edge(vb, ml, mx, my);
        e.x    = 12'(m_x);
        e.y    = 12'(m_y);
        e.busy = (m_mode == M_FALL);
        exp_q.push_back(e);
        @(posedge pclk);
        #2;
    endtask

    // Random button during FALL (must be ignored); released otherwise.
    function automatic bit fall_ml();
        return (m_mode == M_FALL) ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    // A few idle cycles with vblnk low, then one cycle with vblnk high (a tick).
    task automatic frame(input int mx, input int my, input bit hold);
        int n;
        n = int'($urandom_range(1, 4));
        for (int i = 0; i < n; i++) step(1'b0, hold ? 1'b1 : fall_ml(), mx, my);
        step(1'b1, hold ? 1'b1 : fall_ml(), mx, my);
    endtask

    task automatic rnd_frame();
        frame(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b0);
    endtask

    // Scoreboard monitor.
    always @(negedge pclk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("xpos", 32'(bus.xpos), 32'(mon_e.x));
            check("ypos", 32'(bus.ypos), 32'(mon_e.y));
            check("busy", 32'(bus.busy), 32'(mon_e.busy));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int  t3_exp[3];
        bit  seen_hit;
        bit  rebound_pending;
        t3_exp = '{1, 3, 6};

        bus.vblnk      = 1'b0;
        bus.mouse_left = 1'b0;
        bus.mouse_xpos = '0;
        bus.mouse_ypos = '0;
        model_reset();

        // Reset state.
        #12;
        check("reset_xpos", 32'(bus.xpos), 0);
        check("reset_ypos", 32'(bus.ypos), 0);
        check("reset_busy", 32'(bus.busy), 0);
        @(negedge pclk);
        rst = 1'b1;
        #1;

        // Random tracking, including values past the clamp limits.
        for (int i = 0; i < 24; i++)
            step(1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(0, 1023)),
                 int'($urandom_range(0, 1023)));

        // Track and clamp.
        step(1'b0, 1'b0, 100, 50);
        check("t2_track_x", 32'(bus.xpos), 100);
        check("t2_track_y", 32'(bus.ypos), 50);
        step(1'b0, 1'b0, 790, 590);
        check("t2_clamp_x", 32'(bus.xpos), 752);
        check("t2_clamp_y", 32'(bus.ypos), 536);

        // Asynchronous reset in the middle of a fall.
        step(1'b0, 1'b0, 300, 200);
        step(1'b0, 1'b1, 300, 200);
        step(1'b0, 1'b0, 300, 200);
        check("t1_busy_fall", 32'(bus.busy), 1);
        rnd_frame();
        rnd_frame();
        bus.vblnk = 1'b0;
        @(negedge pclk);
        #1;
        rst = 1'b0;
        #1;
        check("t1_rst_xpos", 32'(bus.xpos), 0);
        check("t1_rst_ypos", 32'(bus.ypos), 0);
        check("t1_rst_busy", 32'(bus.busy), 0);
        model_reset();
        @(negedge pclk);
        #1;
        rst = 1'b1;
        step(1'b0, 1'b0, 123, 45);
        check("t1_track_after_x", 32'(bus.xpos), 123);
        check("t1_track_after_y", 32'(bus.ypos), 45);

        // Fall from ypos 0; the tick coinciding with release is not applied.
        step(1'b0, 1'b0, 400, 0);
        step(1'b0, 1'b1, 400, 0);
        step(1'b1, 1'b0, 400, 0);
        check("t3_release_ypos", 32'(bus.ypos), 0);
        check("t3_release_busy", 32'(bus.busy), 1);
        for (int k = 0; k < 3; k++) begin
            rnd_frame();
            check("t3_fall_ypos", 32'(bus.ypos), 32'(t3_exp[k]));
            check("t3_fall_busy", 32'(bus.busy), 1);
        end

        // Continue to the floor, bounce, and come to rest.
        seen_hit        = 1'b0;
        rebound_pending = 1'b0;
        for (int f = 0; f < 300 && m_mode == M_FALL; f++) begin
            m_bounced = 1'b0;
            rnd_frame();
            if (rebound_pending) begin
                check("t4_rebound_ypos", 32'(bus.ypos), 520);
                rebound_pending = 1'b0;
            end
            if (m_bounced) begin
                check("t4_impact_ypos", 32'(bus.ypos), 536);
                if (!seen_hit) begin
                    seen_hit        = 1'b1;
                    rebound_pending = 1'b1;
                end
            end
        end
        check("t4_rest_busy", 32'(bus.busy), 0);
        check("t4_rest_ypos", 32'(bus.ypos), 536);

        // REST ignores ticks; tick and button together return to TRACK.
        rnd_frame();
        rnd_frame();
        step(1'b0, 1'b0, 50, 60);
        step(1'b1, 1'b1, 50, 60);
        check("t5_hold_busy", 32'(bus.busy), 0);
        check("t5_hold_ypos", 32'(bus.ypos), 536);
        step(1'b0, 1'b0, 222, 333);
        check("t5_follow_x", 32'(bus.xpos), 222);
        check("t5_follow_y", 32'(bus.ypos), 333);

        // Mouse moving +5 px per frame before release.
        step(1'b0, 1'b0, 700, 300);
        step(1'b0, 1'b1, 700, 300);
        frame(705, 300, 1'b1);
        frame(710, 300, 1'b1);
        frame(715, 300, 1'b1);
        step(1'b0, 1'b1, 715, 300);
        step(1'b0, 1'b0, 715, 300);
        for (int f = 1; f <= 300 && m_mode == M_FALL; f++) begin
            rnd_frame();
`ifdef RECT_MOTION_HVEL_EN
            if (f == 1) check("t6_first_x", 32'(bus.xpos), 720);
            if (f == 8) check("t6_reflect_x", 32'(bus.xpos), 752);
            if (f == 9) check("t6_after_reflect_x", 32'(bus.xpos), 747);
`else
            if (f == 1) check("t6_frozen_x", 32'(bus.xpos), 715);
`endif
        end
        check("t6_rest_busy", 32'(bus.busy), 0);

        // One more randomized drop.
        step(1'b0, 1'b0, int'($urandom_range(0, 900)), int'($urandom_range(0, 500)));
        step(1'b0, 1'b1, int'($urandom_range(0, 900)), int'($urandom_range(0, 500)));
        step(1'b0, 1'b0, 0, 0);
        for (int f = 0; f < 300 && m_mode == M_FALL; f++) rnd_frame();
        check("rand_rest_busy", 32'(bus.busy), 0);
        step(1'b0, 1'b1, 10, 20);
        step(1'b0, 1'b0, 30, 40);

        repeat (3) @(negedge pclk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
